dp_reg: RTL and testbench

Dual-port register file: 8 entries of 8 bits, one synchronous write port and one independent synchronous read port sharing a single clock. It serves as the processor's general-purpose register storage. Writes and reads to any addresses, including the same address, can occur in the same cycle. Entry count and width are parameterised.

---
 rtl/dp_reg_if.sv | 21 ++
 rtl/dp_reg.sv | 37 +++
 tb/tb_dp_reg.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dp_reg_if.sv
// rtl/dp_reg_if.sv - write/read port bundle for the dp_reg register file
interface dp_reg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output data, write_addr, we, read_addr,
    input  q
  );

  modport slave (
    input  data, write_addr, we, read_addr,
    output q
  );
endinterface

// File: rtl/dp_reg.sv
// rtl/dp_reg.sv - dual-port register file, one write and one registered read port
module dp_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  dp_reg_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_d;

  // Read samples mem_q (pre-edge contents), giving read-before-write on a same-address collision.
  always_comb begin
    mem_d = mem_q;
    q_d   = mem_q[bus.read_addr];
    if (bus.we) begin
      mem_d[bus.write_addr] = bus.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      q_q   <= '0;
    end else begin
      mem_q <= mem_d;
      q_q   <= q_d;
    end
  end

  assign bus.q = q_q;
endmodule

// File: tb/tb_dp_reg.sv
// tb/tb_dp_reg.sv - self-checking bench for dp_reg against an array reference model
module tb_dp_reg;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dp_reg_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  dp_reg #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [8];
  logic [7:0] ref_q;

  task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                       input logic [7:0] d, input logic [2:0] ra);
    rst_n          = r;
    bus.we         = w;
    bus.write_addr = wa;
    bus.data       = d;
    bus.read_addr  = ra;
  endtask

  // Advance one edge; the model reads the old contents before applying the write.
  task automatic tick();
    if (!rst_n) begin
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      ref_q = 8'h00;
    end else begin
      ref_q = ref_mem[bus.read_addr];
      if (bus.we) ref_mem[bus.write_addr] = bus.data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 3'd4, 8'h99, 3'd0);
    tick();
    tick();
    n_cmp++;
    if (bus.q !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_q: got %02h want 00", bus.q);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'(i));
      tick();
      n_cmp++;
      if (bus.q !== 8'h00 || bus.q !== ref_q) begin
        n_bad++;
        $display("FAIL reset_read[%0d]: got %02h want 00", i, bus.q);
      end
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 3'd1, 8'hAA, 3'd0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd1);
    tick();
    n_cmp++;
    if (bus.q !== 8'hAA || bus.q !== ref_q) begin
      n_bad++;
      $display("FAIL basic_read: got %02h want AA", bus.q);
    end
  endtask

  task automatic test_multi();
    logic [7:0] exp_v [3];
    logic [2:0] ra_v  [3];
    exp_v = '{8'hAA, 8'hFE, 8'h0F};
    ra_v  = '{3'd1, 3'd3, 3'd5};
    drive(1'b1, 1'b1, 3'd3, 8'hFE, 3'd0);
    tick();
    drive(1'b1, 1'b1, 3'd5, 8'h0F, 3'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, ra_v[i]);
      tick();
      n_cmp++;
      if (bus.q !== exp_v[i] || bus.q !== ref_q) begin
        n_bad++;
        $display("FAIL multi_read[%0d]: got %02h want %02h", ra_v[i], bus.q, exp_v[i]);
      end
    end
  endtask

  task automatic test_rdw();
    logic [2:0] a_v   [2];
    logic [7:0] old_v [2];
    logic [7:0] new_v [2];
    a_v   = '{3'd3, 3'd5};
    old_v = '{8'hFE, 8'h0F};
    new_v = '{8'h0E, 8'h03};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, a_v[i], new_v[i], a_v[i]);
      tick();
      n_cmp++;
      if (bus.q !== old_v[i] || bus.q !== ref_q) begin
        n_bad++;
        $display("FAIL rdw_old[%0d]: got %02h want %02h", a_v[i], bus.q, old_v[i]);
      end
      drive(1'b1, 1'b0, 3'd0, 8'h00, a_v[i]);
      tick();
      n_cmp++;
      if (bus.q !== new_v[i] || bus.q !== ref_q) begin
        n_bad++;
        $display("FAIL rdw_new[%0d]: got %02h want %02h", a_v[i], bus.q, new_v[i]);
      end
    end
  endtask

  task automatic test_we_protect();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'd1, 8'h55, 3'($urandom_range(0, 7)));
      tick();
    end
    drive(1'b1, 1'b0, 3'd1, 8'h55, 3'd1);
    tick();
    n_cmp++;
    if (bus.q !== 8'hAA || bus.q !== ref_q) begin
      n_bad++;
      $display("FAIL we_protect: got %02h want AA", bus.q);
    end
  endtask

  task automatic test_no_comb_path();
    logic [7:0] held;
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd1);
    tick();
    held = ref_q;
    bus.read_addr  = 3'd3;
    bus.data       = 8'hC3;
    bus.write_addr = 3'd1;
    bus.we         = 1'b1;
    #3;
    n_cmp++;
    if (bus.q !== held) begin
      n_bad++;
      $display("FAIL no_comb_path: got %02h want %02h", bus.q, held);
    end
    bus.we = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [2:0] ra_v [3];
    ra_v = '{3'd1, 3'd2, 3'd3};
    drive(1'b0, 1'b1, 3'd2, 8'h77, 3'd1);
    tick();
    n_cmp++;
    if (bus.q !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset_q: got %02h want 00", bus.q);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, ra_v[i]);
      tick();
      n_cmp++;
      if (bus.q !== 8'h00 || bus.q !== ref_q) begin
        n_bad++;
        $display("FAIL mid_reset_read[%0d]: got %02h want 00", ra_v[i], bus.q);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 7) == 0) bus.read_addr = bus.write_addr;
      tick();
      n_cmp++;
      if (bus.q !== ref_q) begin
        n_bad++;
        $display("FAIL random[%0d]: got %02h want %02h", i, bus.q, ref_q);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0);
    #1;
    test_reset();
    test_basic();
    test_multi();
    test_rdw();
    test_we_protect();
    test_no_comb_path();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
